// File: rtl/buzzer_pkg.sv
// Shared constants for the buzzer: one-hot note and octave codes, the
// middle-octave half-period table at 100 MHz, and the clock-scaling helper.
package buzzer_pkg;

  localparam logic [6:0] NOTE_C = 7'b0000001;
  localparam logic [6:0] NOTE_D = 7'b0000010;
  localparam logic [6:0] NOTE_E = 7'b0000100;
  localparam logic [6:0] NOTE_F = 7'b0001000;
  localparam logic [6:0] NOTE_G = 7'b0010000;
  localparam logic [6:0] NOTE_A = 7'b0100000;
  localparam logic [6:0] NOTE_B = 7'b1000000;

  localparam logic [2:0] PITCH_LOW  = 3'b001;
  localparam logic [2:0] PITCH_MID  = 3'b010;
  localparam logic [2:0] PITCH_HIGH = 3'b100;

  localparam int unsigned REF_CLK_HZ = 100000000;

  localparam int unsigned MID_HALF_C = 191110;
  localparam int unsigned MID_HALF_D = 170265;
  localparam int unsigned MID_HALF_E = 151685;
  localparam int unsigned MID_HALF_F = 143172;
  localparam int unsigned MID_HALF_G = 127551;
  localparam int unsigned MID_HALF_A = 113636;
  localparam int unsigned MID_HALF_B = 101239;

  // One ROM word of the song table: {note, pitch}; all-zero is a rest.
  typedef struct packed {
    logic [6:0] note;
    logic [2:0] pitch;
  } code_t;

  localparam code_t REST_CODE = '0;

  // Rescale a 100 MHz half-period to the actual clock, rounding to nearest.
  function automatic logic [19:0] scaleHalf(input int unsigned base,
                                            input int unsigned clkHz);
    longint unsigned scaled;
    scaled = (64'(base) * 64'(clkHz) + 64'(REF_CLK_HZ / 2)) / 64'(REF_CLK_HZ);
    return scaled[19:0];
  endfunction

endpackage

// File: rtl/buzzer_period_lut.sv
// Combinational map from a {note, pitch} code to its tone half-period in
// clock cycles, plus a flag saying whether the code is a playable note.
module buzzer_period_lut
  import buzzer_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100000000
) (
  input  logic [6:0]  note_i,
  input  logic [2:0]  pitch_i,
  output logic [19:0] halfPeriod_o,
  output logic        legal_o
);

  localparam logic [19:0] HALF_C = scaleHalf(MID_HALF_C, CLK_FREQ_HZ);
  localparam logic [19:0] HALF_D = scaleHalf(MID_HALF_D, CLK_FREQ_HZ);
  localparam logic [19:0] HALF_E = scaleHalf(MID_HALF_E, CLK_FREQ_HZ);
  localparam logic [19:0] HALF_F = scaleHalf(MID_HALF_F, CLK_FREQ_HZ);
  localparam logic [19:0] HALF_G = scaleHalf(MID_HALF_G, CLK_FREQ_HZ);
  localparam logic [19:0] HALF_A = scaleHalf(MID_HALF_A, CLK_FREQ_HZ);
  localparam logic [19:0] HALF_B = scaleHalf(MID_HALF_B, CLK_FREQ_HZ);

  logic [19:0] midHalf;

  // Octaves are exact factors of two, so low/high are plain shifts of the middle.
  always_comb begin
    midHalf = '0;
    case (note_i)
      NOTE_C:  midHalf = HALF_C;
      NOTE_D:  midHalf = HALF_D;
      NOTE_E:  midHalf = HALF_E;
      NOTE_F:  midHalf = HALF_F;
      NOTE_G:  midHalf = HALF_G;
      NOTE_A:  midHalf = HALF_A;
      NOTE_B:  midHalf = HALF_B;
      default: midHalf = '0;
    endcase

    halfPeriod_o = midHalf;
    case (pitch_i)
      PITCH_LOW:  halfPeriod_o = midHalf << 1;
      PITCH_HIGH: halfPeriod_o = midHalf >> 1;
      default:    halfPeriod_o = midHalf;
    endcase

    legal_o = $onehot(note_i) && $onehot(pitch_i);
  end

endmodule

// File: rtl/buzzer.sv
// Square-wave tone generator driven by a {note, pitch} ROM word.
// Define BUZZER_MARKLED_EN to get a registered tone-active LED on markLED.
module buzzer
  import buzzer_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       stop,
  input  logic [6:0] note,
  input  logic [2:0] pitch,
  output logic       speaker,
  output logic       sel,
  output logic       markLED
);

  code_t       codeIn;
  code_t       code_q;
  logic [19:0] count_q, count_d;
  logic        speaker_q, speaker_d;
  logic [19:0] halfPeriod;
  logic        codeLegal;
  logic        playing;

  assign codeIn = '{note: note, pitch: pitch};

  buzzer_period_lut #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ)
  ) u_lut (
    .note_i      (code_q.note),
    .pitch_i     (code_q.pitch),
    .halfPeriod_o(halfPeriod),
    .legal_o     (codeLegal)
  );

  // A code change restarts the tone from silence, so a new note always
  // begins with a full half-period of low output.
  always_comb begin
    playing   = !stop && codeLegal && (code_q == codeIn);
    count_d   = count_q;
    speaker_d = speaker_q;
    if (!playing) begin
      count_d   = '0;
      speaker_d = 1'b0;
    end else if (count_q == halfPeriod - 20'd1) begin
      count_d   = '0;
      speaker_d = !speaker_q;
    end else begin
      count_d = count_q + 20'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      code_q    <= REST_CODE;
      count_q   <= '0;
      speaker_q <= 1'b0;
    end else begin
      code_q    <= codeIn;
      count_q   <= count_d;
      speaker_q <= speaker_d;
    end
  end

  assign speaker = speaker_q;
  assign sel     = 1'b1;

`ifdef BUZZER_MARKLED_EN
  logic markLed_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      markLed_q <= 1'b0;
    end else begin
      markLed_q <= playing;
    end
  end

  assign markLED = markLed_q;
`else
  assign markLED = 1'b0;
`endif

endmodule

// File: tb/tb_buzzer.sv
// Self-checking bench for buzzer: directed scenarios plus random segments,
// compared every cycle against a tone model built from elapsed-cycle arithmetic.
module tb_buzzer;

  localparam int unsigned CLK_HZ = 200000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stop;
  logic [6:0] note;
  logic [2:0] pitch;
  logic       speaker;
  logic       sel;
  logic       markLED;

  int checks = 0;
  int fails  = 0;

  int         runLen   = 0;
  logic [9:0] prevCode = '0;
  logic       expSpk   = 1'b0;
  logic       expMark  = 1'b0;

  buzzer #(
    .CLK_FREQ_HZ(CLK_HZ)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .stop   (stop),
    .note   (note),
    .pitch  (pitch),
    .speaker(speaker),
    .sel    (sel),
    .markLED(markLED)
  );

  always #5 clk = ~clk;

  // Tone model: half-period from the note frequency table at 100 MHz,
  // rescaled to CLK_HZ and doubled/halved for the octave.
  function automatic int modelHalf(input logic [9:0] code);
    int unsigned midTable [7];
    int          idx;
    longint      scaled;
    midTable = '{191110, 170265, 151685, 143172, 127551, 113636, 101239};
    idx = 0;
    for (int i = 0; i < 7; i++) if (code[3+i]) idx = i;
    scaled = (longint'(midTable[idx]) * CLK_HZ + 50000000) / 100000000;
    if (code[0]) scaled = scaled * 2;
    else if (code[2]) scaled = scaled / 2;
    return int'(scaled);
  endfunction

  function automatic bit modelLegal(input logic [9:0] code);
    return ($countones(code[9:3]) == 1) && ($countones(code[2:0]) == 1);
  endfunction

  // Speaker is high during odd-numbered half-periods of an uninterrupted run.
  task automatic modelStep();
    logic [9:0] code;
    bit         play;
    code = {note, pitch};
    if (!rst_n) begin
      runLen   = 0;
      prevCode = '0;
      expMark  = 1'b0;
    end else begin
      play     = !stop && (code == prevCode) && modelLegal(code);
      runLen   = play ? runLen + 1 : 0;
      prevCode = code;
`ifdef BUZZER_MARKLED_EN
      expMark  = play;
`else
      expMark  = 1'b0;
`endif
    end
    expSpk = (runLen == 0) ? 1'b0 : 1'(((runLen / modelHalf(prevCode)) % 2));
  endtask

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0b expected %0b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput("speaker", speaker, expSpk);
    checkOutput("markLED", markLED, expMark);
    checkOutput("sel", sel, 1'b1);
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic [6:0] n,
                               input logic [2:0] p, input int cycles);
    rst_n = r;
    stop  = s;
    note  = n;
    pitch = p;
    repeat (cycles) stepCycle();
  endtask

  function automatic logic [6:0] randNote();
    if ($urandom_range(0, 99) < 85) return 7'(1 << $urandom_range(0, 6));
    return 7'($urandom);
  endfunction

  function automatic logic [2:0] randPitch();
    if ($urandom_range(0, 99) < 85) return 3'(1 << $urandom_range(0, 2));
    return 3'($urandom);
  endfunction

  initial begin
    rst_n = 1'b0;
    stop  = 1'b0;
    note  = '0;
    pitch = '0;

    applyStimulus(1'b0, 1'($urandom), randNote(), randPitch(), 3);

    applyStimulus(1'b1, 1'b0, 7'b0000001, 3'b010, 900);

    applyStimulus(1'b1, 1'b0, 7'b0100000, 3'b001, 1000);
    applyStimulus(1'b1, 1'b0, 7'b0100000, 3'b100, 300);

    applyStimulus(1'b1, 1'b0, 7'b0000001, 3'b010, 200);
    applyStimulus(1'b1, 1'b1, 7'b0000001, 3'b010, 10);
    applyStimulus(1'b1, 1'b0, 7'b0000001, 3'b010, 500);

    applyStimulus(1'b1, 1'b0, 7'b0000011, 3'b010, 100);
    applyStimulus(1'b1, 1'b0, 7'b0000001, 3'b000, 100);

    applyStimulus(1'b1, 1'b0, 7'b0010000, 3'b010, 400);
    applyStimulus(1'b1, 1'b0, 7'b0000100, 3'b010, 700);

    applyStimulus(1'b1, 1'b0, 7'b0000001, 3'b010, 200);
    applyStimulus(1'b0, 1'b0, 7'b0000001, 3'b010, 3);
    applyStimulus(1'b1, 1'b0, 7'b0000001, 3'b010, 500);

    applyStimulus(1'b1, 1'b0, 7'b0010000, 3'b010, 100);
    applyStimulus(1'b1, 1'b1, 7'b0000100, 3'b010, 5);
    applyStimulus(1'b1, 1'b0, 7'b0000100, 3'b010, 400);

    for (int seg = 0; seg < 30; seg++) begin
      applyStimulus(($urandom_range(0, 99) >= 5),
                    ($urandom_range(0, 99) < 15),
                    randNote(), randPitch(),
                    int'($urandom_range(1, 700)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
